// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (shift-right / subtract-3).
// One shift per clock; start/busy/done handshake; flags any digit above 9.
// The DONE state captures the result; done, bin_out and err appear on the
// following edge, so a back-to-back start accepted in DONE keeps the
// conversion period at BIN_W+1 cycles.
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Largest representable BCD value, used to reject undersized BIN_W.
  function automatic logic [63:0] max_bcd_val(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_bcd_val(NUM_DIGITS);

  generate
    if (NUM_DIGITS < 1) begin : g_bad_digits
      $error("bcd_to_bin_seq: NUM_DIGITS must be at least 1");
    end
    if (BIN_W < 64 && ((64'd1 << BIN_W) <= MAX_VAL)) begin : g_bad_width
      $error("bcd_to_bin_seq: BIN_W too narrow for NUM_DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // One conversion step: shift right, then pull every BCD field that
  // received a bit from above (>= 8) back by 3 to undo the decimal weight.
  function automatic logic [WORK_W-1:0] shift_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] r;
    r = w >> 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[BIN_W+4*i +: 4] >= 4'd8) begin
        r[BIN_W+4*i +: 4] = r[BIN_W+4*i +: 4] - 4'd3;
      end
    end
    return r;
  endfunction

  // True when any packed digit is outside 0..9.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q,  work_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               bad_q,   bad_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;
  logic               err_q,   err_d;

  // State, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: load on start when idle/done, shift BIN_W times.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          bin_d  = bad_q ? '0 : work_q[BIN_W-1:0];
          err_d  = bad_q;
          done_d = 1'b1;
        end
        if (start) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          bad_d   = has_bad_digit(bcd_in);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = shift_step(work_q);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule
